// File: rtl/adder_chk_pkg.sv
// adder_chk_pkg: shared state encoding, latency bound and golden adder for the adder response checker.
package adder_chk_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    localparam int LATENCY_MAX = 7;
    localparam int ADD_W_MAX   = 32;

    // Operands are zero-extended to ADD_W_MAX; the caller truncates to its WIDTH+1 result
    function automatic logic [ADD_W_MAX:0] golden_add(
        input logic [ADD_W_MAX-1:0] a,
        input logic [ADD_W_MAX-1:0] b,
        input logic                 cin
    );
        return {1'b0, a} + {1'b0, b} + {{ADD_W_MAX{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/adder_chk_delay_line.sv
// adder_chk_delay_line: valid+data shift register of DEPTH stages; DEPTH=0 is a pure pass-through.
module adder_chk_delay_line #(
    parameter int DEPTH = 0,
    parameter int DW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    if (DEPTH == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk & rst_n;
        assign valid_o = valid_i;
        assign data_o  = data_i;
    end else begin : g_pipe
        logic [DEPTH-1:0] vld_q;
        logic [DW-1:0]    dat_q [DEPTH];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
            end else begin
                vld_q[0] <= valid_i;
                dat_q[0] <= data_i;
                for (int i = 1; i < DEPTH; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
        assign valid_o = vld_q[DEPTH-1];
        assign data_o  = dat_q[DEPTH-1];
    end

endmodule

// File: rtl/adder_response_checker.sv
// adder_response_checker: golden-model checker aligning expected adder results to DUT latency and tallying pass/fail.
// Define ADDER_CHK_FIRST_FAIL_EN to add first-mismatch capture ports (index, expected, got).
module adder_response_checker
    import adder_chk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 0,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] num_vectors,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    input  logic [WIDTH-1:0]   sum,
    input  logic               carry,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] pass_count,
    output logic [COUNT_W-1:0] fail_count,
    output logic               err
`ifdef ADDER_CHK_FIRST_FAIL_EN
    ,
    output logic [COUNT_W-1:0] first_fail_idx,
    output logic [WIDTH:0]     first_fail_exp,
    output logic [WIDTH:0]     first_fail_got
`endif
);

    localparam int DEPTH = (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
`ifdef ADDER_CHK_FIRST_FAIL_EN
    localparam int DW = WIDTH + 1 + COUNT_W;
`else
    localparam int DW = WIDTH + 1;
`endif

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] nv_q, nv_d, issued_q, issued_d, pass_q, pass_d, fail_q, fail_d;
    logic               err_q, err_d;
    logic [WIDTH:0]     exp_now, cmp_exp, got;
    logic [DW-1:0]      push_data, pop_data;
    logic               start_ok, accept, pop_valid, hit, miss;
    logic [COUNT_W:0]   retired;

    assign exp_now  = (WIDTH+1)'(golden_add(ADD_W_MAX'(a), ADD_W_MAX'(b), cin));
    assign start_ok = start && (state_q == IDLE || state_q == DONE);
    assign accept   = in_valid && state_q == RUN && issued_q < nv_q;
    assign cmp_exp  = pop_data[WIDTH:0];
    assign got      = {carry, sum};
    assign hit      = pop_valid && got == cmp_exp;
    assign miss     = pop_valid && got != cmp_exp;

    adder_chk_delay_line #(.DEPTH(DEPTH), .DW(DW)) u_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid_i(accept),
        .data_i (push_data),
        .valid_o(pop_valid),
        .data_o (pop_data)
    );

    always_comb begin
        nv_d     = start_ok ? num_vectors : nv_q;
        issued_d = start_ok ? '0 : issued_q + COUNT_W'(accept);
        pass_d   = start_ok ? '0 : pass_q + COUNT_W'(hit && !(&pass_q));
        fail_d   = start_ok ? '0 : fail_q + COUNT_W'(miss && !(&fail_q));
        err_d    = !start_ok && (err_q || miss);
        retired  = {1'b0, pass_d} + {1'b0, fail_d};
    end

    // DRAIN looks at the next-cycle tallies so DONE lands together with the final count
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = (num_vectors == '0) ? DONE : RUN;
            RUN:        if (accept && issued_d == nv_q) state_d = DRAIN;
            DRAIN:      if (retired == {1'b0, nv_q}) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = state_q == RUN || state_q == DRAIN;
        done = state_q == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            nv_q     <= '0;
            issued_q <= '0;
            pass_q   <= '0;
            fail_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            nv_q     <= nv_d;
            issued_q <= issued_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            err_q    <= err_d;
        end
    end

    assign pass_count = pass_q;
    assign fail_count = fail_q;
    assign err        = err_q;

`ifdef ADDER_CHK_FIRST_FAIL_EN
    logic [COUNT_W-1:0] ff_idx_q;
    logic [WIDTH:0]     ff_exp_q, ff_got_q;

    // The vector index rides in the upper bits of the delay line
    assign push_data = {issued_q, exp_now};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_idx_q <= '0;
            ff_exp_q <= '0;
            ff_got_q <= '0;
        end else if (start_ok) begin
            ff_idx_q <= '0;
            ff_exp_q <= '0;
            ff_got_q <= '0;
        end else if (miss && fail_q == '0) begin
            ff_idx_q <= pop_data[DW-1:WIDTH+1];
            ff_exp_q <= cmp_exp;
            ff_got_q <= got;
        end
    end

    assign first_fail_idx = ff_idx_q;
    assign first_fail_exp = ff_exp_q;
    assign first_fail_got = ff_got_q;
`else
    assign push_data = exp_now;
`endif

endmodule

// File: tb/tb_adder_response_checker.sv
// tb_adder_response_checker: drives a zero-latency and a two-cycle adder stand-in into two checker instances.
`timescale 1ns/1ps
module tb_adder_response_checker;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [4:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n, start, in_valid, cin, fault, use_tbl;
    logic [7:0] num;
    logic [3:0] a, b;
    logic [4:0] tbl_res, res_now, p1, p2;
    logic       busy0, done0, err0, busy2, done2, err2;
    logic [7:0] pc0, fc0, pc2, fc2;
    int         n_chk = 0;
    int         n_fail = 0;
`ifdef ADDER_CHK_FIRST_FAIL_EN
    logic [7:0] fi0, fi2;
    logic [4:0] fe0, fg0, fe2, fg2;
`endif

    always #5 clk = ~clk;

    // Adder stand-in: true sum, optional carry fault on 15+15+1, or a forced table value
    always_comb begin
        res_now = 5'(a) + 5'(b) + 5'(cin);
        if (fault && a == 4'hf && b == 4'hf && cin) res_now[4] = 1'b0;
        if (use_tbl) res_now = tbl_res;
    end

    always_ff @(posedge clk) begin
        p1 <= res_now;
        p2 <= p1;
    end

    adder_response_checker #(.WIDTH(4), .LATENCY(0), .COUNT_W(8)) u_l0 (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num), .in_valid(in_valid),
        .a(a), .b(b), .cin(cin), .sum(res_now[3:0]), .carry(res_now[4]),
        .busy(busy0), .done(done0), .pass_count(pc0), .fail_count(fc0), .err(err0)
`ifdef ADDER_CHK_FIRST_FAIL_EN
        , .first_fail_idx(fi0), .first_fail_exp(fe0), .first_fail_got(fg0)
`endif
    );

    adder_response_checker #(.WIDTH(4), .LATENCY(2), .COUNT_W(8)) u_l2 (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num), .in_valid(in_valid),
        .a(a), .b(b), .cin(cin), .sum(p2[3:0]), .carry(p2[4]),
        .busy(busy2), .done(done2), .pass_count(pc2), .fail_count(fc2), .err(err2)
`ifdef ADDER_CHK_FIRST_FAIL_EN
        , .first_fail_idx(fi2), .first_fail_exp(fe2), .first_fail_got(fg2)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        num   = 8'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic issue(input logic [3:0] x, input logic [3:0] y, input logic c);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (!(done0 && done2) && k < 40) begin
            tick();
            k++;
        end
        check({nm, "_done"}, int'(done0 && done2), 1);
    endtask

    task automatic check_counts(input string nm, input int p, input int f, input int e);
        check({nm, "_pass_l0"}, int'(pc0), p);
        check({nm, "_fail_l0"}, int'(fc0), f);
        check({nm, "_err_l0"}, int'(err0), e);
        check({nm, "_pass_l2"}, int'(pc2), p);
        check({nm, "_fail_l2"}, int'(fc2), f);
        check({nm, "_err_l2"}, int'(err2), e);
    endtask

    initial begin
        vec_t tv[8];
        int   acc, exp_f, first, pulses, p;
        logic [3:0] x, y;
        logic       c;
        tv[0] = '{4'd0,  4'd9,  1'b0, 5'b01001};
        tv[1] = '{4'd0,  4'd9,  1'b1, 5'b01010};
        tv[2] = '{4'd15, 4'd0,  1'b0, 5'b01111};
        tv[3] = '{4'd15, 4'd0,  1'b1, 5'b10000};
        tv[4] = '{4'd3,  4'd12, 1'b0, 5'b01111};
        tv[5] = '{4'd3,  4'd12, 1'b1, 5'b10000};
        tv[6] = '{4'd15, 4'd15, 1'b0, 5'b11110};
        tv[7] = '{4'd15, 4'd15, 1'b1, 5'b11111};
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        num = '0; fault = 1'b0; use_tbl = 1'b0; tbl_res = '0;
        tick();
        tick();
        check("reset_l0", int'({busy0, done0, err0, pc0, fc0}), 0);
        check("reset_l2", int'({busy2, done2, err2, pc2, fc2}), 0);
        rst_n = 1'b1;
        tick();

        // Directed table: the stand-in returns the table's expected value, so passes confirm the golden sum
        use_tbl = 1'b1;
        do_start(8);
        check("run_busy", int'(busy0), 1);
        for (int i = 0; i < 8; i++) begin
            tbl_res = tv[i].exp;
            issue(tv[i].a, tv[i].b, tv[i].cin);
            check($sformatf("tbl_pass_%0d", i), int'(pc0), i + 1);
        end
        tick();
        check("tbl_done_l0", int'(done0), 1);
        check("tbl_done_l2_early", int'(done2), 0);
        tick();
        check("tbl_done_l2_at3", int'(done2), 1);
        check_counts("tbl", 8, 0, 0);
        use_tbl = 1'b0;

        // Carry fault on (15,15,1)
        fault = 1'b1;
        do_start(8);
        for (int i = 0; i < 8; i++) issue(tv[i].a, tv[i].b, tv[i].cin);
        wait_done("fault");
        check_counts("fault", 7, 1, 1);
`ifdef ADDER_CHK_FIRST_FAIL_EN
        check("fault_idx_l0", int'(fi0), 7);
        check("fault_exp_l0", int'(fe0), 31);
        check("fault_got_l0", int'(fg0), 15);
        check("fault_idx_l2", int'(fi2), 7);
        check("fault_got_l2", int'(fg2), 15);
`endif
        fault = 1'b0;

        // Zero-vector run completes immediately
        do_start(0);
        check("zero_done", int'(done0 && done2), 1);
        check("zero_busy", int'(busy0 || busy2), 0);
        check_counts("zero", 0, 0, 0);

        // Surplus in_valid beyond num_vectors is ignored
        do_start(4);
        for (int i = 0; i < 10; i++) issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        wait_done("surplus");
        check_counts("surplus", 4, 0, 0);

        // Randomised runs against a counting model of accepted vectors
        fault = 1'b1;
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, 12));
            do_start(n);
            acc = 0; exp_f = 0; first = -1; p = 0;
            pulses = n + int'($urandom_range(0, 3));
            while (p < pulses) begin
                if ($urandom_range(0, 2) == 0) tick();
                if ($urandom_range(0, 3) == 0) begin
                    x = 4'hf; y = 4'hf; c = 1'b1;
                end else begin
                    x = 4'($urandom_range(0, 15)); y = 4'($urandom_range(0, 15)); c = 1'($urandom_range(0, 1));
                end
                if (acc < n) begin
                    if (x == 4'hf && y == 4'hf && c) begin
                        if (first < 0) first = acc;
                        exp_f++;
                    end
                    acc++;
                end
                issue(x, y, c);
                p++;
            end
            wait_done($sformatf("rand%0d", r));
            check_counts($sformatf("rand%0d", r), n - exp_f, exp_f, (exp_f > 0) ? 1 : 0);
`ifdef ADDER_CHK_FIRST_FAIL_EN
            check($sformatf("rand%0d_idx", r), int'(fi2), (first < 0) ? 0 : first);
            check($sformatf("rand%0d_exp", r), int'(fe0), (first < 0) ? 0 : 31);
`endif
        end
        fault = 1'b0;

        // Reset in the middle of a run
        do_start(5);
        for (int i = 0; i < 3; i++) issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        check("pre_rst_pass", int'(pc0), 3);
        rst_n = 1'b0;
        #1;
        check("midrst_l0", int'({busy0, done0, err0, pc0, fc0}), 0);
        check("midrst_l2", int'({busy2, done2, err2, pc2, fc2}), 0);
        tick();
        rst_n = 1'b1;
        tick();
        do_start(2);
        issue(4'd7, 4'd8, 1'b1);
        issue(4'd2, 4'd5, 1'b0);
        wait_done("post_rst");
        check_counts("post_rst", 2, 0, 0);

        // start while busy must not restart or resize the run
        do_start(3);
        issue(4'd1, 4'd2, 1'b0);
        start = 1'b1;
        num   = 8'd6;
        issue(4'd4, 4'd4, 1'b1);
        start = 1'b0;
        for (int i = 0; i < 4; i++) issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        wait_done("busy_start");
        check_counts("busy_start", 3, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_response_checker.md
Name: adder_response_checker

Overview:
Self-checking response end for the 4-bit adder benches, including the carry select adder. A stimulus source drives operands and the adder returns sum/carry. This block computes the golden result for each issued vector and aligns it to the DUT's result latency. It compares the two, keeps pass/fail tallies, and signals completion once a programmed number of vectors has been checked.

Parameters:
WIDTH, 4, operand and sum width in bits
LATENCY, 0, cycles between in_valid with operands and the matching DUT sum/carry (legal 0..7)
COUNT_W, 8, width of vector counters and num_vectors

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; arms a run of num_vectors checks
num_vectors  input  COUNT_W  vectors to check in this run; sampled on start
in_valid  input  1  operands a/b/cin are being issued to the DUT this cycle
a  input  WIDTH  operand A as driven to the DUT
b  input  WIDTH  operand B as driven to the DUT
cin  input  1  carry-in as driven to the DUT
sum  input  WIDTH  DUT sum
carry  input  1  DUT carry-out
busy  output  1  high in RUN and DRAIN
done  output  1  high in DONE until next start
pass_count  output  COUNT_W  matching vectors this run
fail_count  output  COUNT_W  mismatching vectors this run
err  output  1  sticky; set on any mismatch this run

Behaviour:
- Reset (async, rst_n=0): state IDLE. busy=0, done=0, pass_count=0, fail_count=0, err=0. Issued counter cleared. Delay line cleared, with all valid bits 0.
- Golden value: exp = a + b + cin, computed at WIDTH+1 bits. exp[WIDTH] is the carry and exp[WIDTH-1:0] is the sum.
- Alignment:
  - On an accepted in_valid, {1,exp} enters a LATENCY-stage valid/data shift register.
  - LATENCY=0: the compare uses the same cycle's exp against sum/carry.
  - Compare fires when the delay-line output is valid. Match if {carry,sum}==exp.
  - Counters and err register on the next clock edge. Result visible 1 cycle after the compare cycle.
- FSM:
  - IDLE: start -> RUN. Clears counters, err and issued count, and latches num_vectors. If num_vectors==0, go -> DONE instead.
  - RUN: in_valid is accepted while issued<num_vectors. in_valid beyond num_vectors is ignored and not pushed. When issued reaches num_vectors -> DRAIN.
  - DRAIN: waits until pass_count+fail_count==num_vectors (all in-flight compares retired) -> DONE.
  - DONE: done=1 and counters held. start -> RUN with the same clearing as from IDLE.
- in_valid in IDLE or DONE: ignored. No push, no count.
- start while busy: ignored.
- Counters saturate at 2^COUNT_W-1. Wrap is not allowed.
- Last accepted vector and transition to DRAIN in the same cycle: the vector is still pushed and checked.
- Reset mid-run: everything clears immediately and in-flight compares are discarded.
- Outputs are registered except busy/done, which decode the state register.

Optional Feature:
Macro ADDER_CHK_FIRST_FAIL_EN.
- Defined: adds output ports first_fail_idx (COUNT_W), first_fail_exp (WIDTH+1) and first_fail_got (WIDTH+1).
  - They capture the 0-based vector index, expected {carry,sum} and DUT {carry,sum} of the first mismatch in a run.
  - Held until the next start. Cleared to 0 on reset and on start.
  - Requires the index to travel with the delay line.
- Undefined: ports, capture registers and index tracking are absent. All other behaviour is identical.

Decomposition:
- Package adder_chk_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - LATENCY_MAX=7
  - function golden_add(a,b,cin) returning WIDTH+1 bits
- One sub-module: adder_chk_delay_line.
  - Parameterised depth (LATENCY) and data width.
  - valid+data shift register, reset to invalid.
  - Depth 0 is pure pass-through.

Test Plan:
- LATENCY=0, num_vectors=8, correct model. Vectors (0,9,0) (0,9,1) (15,0,0) (15,0,1) (3,12,0) (3,12,1) (15,15,0) (15,15,1). Expected {carry,sum} 0_1001, 0_1010, 0_1111, 1_0000, 0_1111, 1_0000, 1_1110, 1_1111. Required: pass=8, fail=0, err=0, done=1.
- LATENCY=2, DUT result delayed 2 cycles, 8 vectors. Required: pass=8 and done asserts 3 cycles after the last in_valid.
- Faulty DUT forcing carry=0 for (15,15,1). Required: fail=1, pass=7, err=1. With ADDER_CHK_FIRST_FAIL_EN: idx=7, exp=5'b11111, got=5'b01111.
- num_vectors=0 then start -> done=1 the next cycle with counts 0. Also, 10 in_valid pulses with num_vectors=4 -> exactly 4 counted.
- rst_n low for 1 cycle mid-RUN after 3 vectors -> all outputs 0 and IDLE. A new start with 2 vectors -> pass=2.
- start pulsed while busy -> ignored, and the run completes with the original num_vectors.
